// File: rtl/reg_write_arbiter.sv
// Write-port arbiter between the pipeline writeback and a multi-cycle unit.
// Deferred MDU results sit in a small FIFO, get killed by younger pipeline writes, and are bypassed to the read ports.
module reg_write_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbValid,
   input  logic [4:0]  wbAdr,
   input  logic [31:0] wbData,
   input  logic        mduValid,
   input  logic [4:0]  mduAdr,
   input  logic [31:0] mduData,
   output logic        mduReady,
   output logic        regWrite,
   output logic [4:0]  writeAdr,
   output logic [31:0] writeData,
   input  logic [4:0]  adr1,
   input  logic [4:0]  adr2,
   input  logic [31:0] rfData1,
   input  logic [31:0] rfData2,
   output logic [31:0] readData1,
   output logic [31:0] readData2,
   output logic        pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [4:0]       adr_mem  [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [DEPTH-1:0] live;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] idx;

   logic wb_write;
   logic push;
   logic pop;

   // Readiness looks only at the current count, so a full buffer stays closed even while popping.
   assign mduReady = !rst && (count < CNT_W'(DEPTH));
   assign wb_write = wbValid && (wbAdr != '0);
   assign pop      = !wb_write && (count != '0);
   assign push     = mduValid && mduReady && (mduAdr != '0);
   assign pending  = !rst && (|live);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      regWrite  = 1'b0;
      writeAdr  = '0;
      writeData = '0;
      if (!rst) begin
         if (wb_write) begin
            regWrite  = 1'b1;
            writeAdr  = wbAdr;
            writeData = wbData;
         end else if (pop) begin
            regWrite  = live[head];
            writeAdr  = adr_mem[head];
            writeData = data_mem[head];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         live  <= '0;
      end else begin
         if (wb_write) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (adr_mem[i] == wbAdr) live[i] <= 1'b0;
            end
         end
         if (pop) begin
            live[head] <= 1'b0;
            head       <= head + PTR_W'(1);
         end
         // Applied after the kill loop: a same-cycle MDU result is younger than the pipeline write.
         if (push) begin
            live[tail] <= 1'b1;
            tail       <= tail + PTR_W'(1);
         end
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // NOTE: payload storage is not reset; live bits alone decide whether an entry means anything.
   always_ff @(posedge clk) begin
      if (push) begin
         adr_mem[tail]  <= mduAdr;
         data_mem[tail] <= mduData;
      end
   end

   // Walk oldest to youngest so the youngest live match wins.
   always_comb begin
      readData1 = rfData1;
      readData2 = rfData2;
      idx       = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && live[idx]) begin
            if (adr_mem[idx] == adr1) readData1 = data_mem[idx];
            if (adr_mem[idx] == adr2) readData2 = data_mem[idx];
         end
      end
      if (adr1 == '0) readData1 = '0;
      if (adr2 == '0) readData2 = '0;
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a queue-based reference model predicts writes,
// a monitor matches every regWrite against the expected-write queue by cycle, address and data.
module tb_reg_write_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbValid, mduValid, mduReady, regWrite, pending;
   logic [4:0]  wbAdr, mduAdr, writeAdr, adr1, adr2;
   logic [31:0] wbData, mduData, writeData, rfData1, rfData2, readData1, readData2;

   typedef struct {
      logic [4:0]  adr;
      logic [31:0] data;
      bit          live;
   } entry_t;

   typedef struct {
      int          stamp;
      logic [4:0]  adr;
      logic [31:0] data;
   } wr_t;

   entry_t model_q[$];
   wr_t    exp_q[$];
   int     cyc = 0;
   int     tests = 0;
   int     fails = 0;

   reg_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wbValid(wbValid), .wbAdr(wbAdr), .wbData(wbData),
      .mduValid(mduValid), .mduAdr(mduAdr), .mduData(mduData), .mduReady(mduReady),
      .regWrite(regWrite), .writeAdr(writeAdr), .writeData(writeData),
      .adr1(adr1), .adr2(adr2), .rfData1(rfData1), .rfData2(rfData2),
      .readData1(readData1), .readData2(readData2), .pending(pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'd0;
      for (int i = model_q.size() - 1; i >= 0; i--)
         if (model_q[i].live && model_q[i].adr == a) return model_q[i].data;
      return rf;
   endfunction

   // Monitor: every write the DUT presents must be the oldest expected write, in the same cycle.
   always @(negedge clk) begin
      wr_t e;
      if (rst === 1'b0 && regWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, writeAdr, writeData}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("write_cycle", 64'(cyc), 64'(e.stamp));
            check("write_adr", 64'(writeAdr), 64'(e.adr));
            check("write_data", 64'(writeData), 64'(e.data));
         end
      end
   end

   task automatic drive_cycle(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                              input bit mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] r1, input logic [31:0] r2);
      bit          ready, wb, idle, exp_pend;
      logic [31:0] e1, e2;
      entry_t      h;
      @(posedge clk);
      #1;
      wbValid = wv; wbAdr = wa; wbData = wd;
      mduValid = mv; mduAdr = ma; mduData = md;
      adr1 = a1; adr2 = a2; rfData1 = r1; rfData2 = r2;
      ready = model_q.size() < DEPTH;
      wb    = wv && (wa != 5'd0);
      idle  = !wb && model_q.size() == 0;
      e1    = model_read(a1, r1);
      e2    = model_read(a2, r2);
      exp_pend = 1'b0;
      foreach (model_q[i]) if (model_q[i].live) exp_pend = 1'b1;
      if (wb) begin
         exp_q.push_back('{cyc, wa, wd});
         foreach (model_q[i]) if (model_q[i].adr == wa) model_q[i].live = 1'b0;
      end else if (model_q.size() > 0) begin
         h = model_q.pop_front();
         if (h.live) exp_q.push_back('{cyc, h.adr, h.data});
      end
      if (mv && ready && ma != 5'd0) model_q.push_back('{ma, md, 1'b1});
      #3;
      check("mdu_ready", 64'(mduReady), 64'(ready));
      check("read_data1", 64'(readData1), 64'(e1));
      check("read_data2", 64'(readData2), 64'(e2));
      check("pending", 64'(pending), 64'(exp_pend));
      if (idle) check("idle_port", {27'd0, regWrite, writeAdr, writeData}, 64'd0);
   endtask

   task automatic drive_idle();
      drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
   endtask

   // Asynchronous reset pulse between edges, with idle inputs so nothing is accepted around it.
   task automatic do_reset();
      @(posedge clk);
      #1;
      wbValid = 0; wbAdr = 0; wbData = 0; mduValid = 0; mduAdr = 0; mduData = 0;
      adr1 = 5'd3; adr2 = 5'd0; rfData1 = 32'h1234_5678; rfData2 = 32'h9abc_def0;
      #1 rst = 1'b1;
      #1;
      check("rst_port", {27'd0, regWrite, writeAdr, writeData}, 64'd0);
      check("rst_ready_pending", {62'd0, mduReady, pending}, 64'd0);
      check("rst_read1", 64'(readData1), 64'h1234_5678);
      check("rst_read2", 64'(readData2), 64'd0);
      model_q.delete();
      exp_q.delete();
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wbValid = 0; wbAdr = 0; wbData = 0; mduValid = 0; mduAdr = 0; mduData = 0;
      adr1 = 0; adr2 = 0; rfData1 = 0; rfData2 = 0;
      repeat (2) @(posedge clk);
      #2;
      check("init_port", {27'd0, regWrite, writeAdr, writeData}, 64'd0);
      check("init_ready_pending", {62'd0, mduReady, pending}, 64'd0);
      rst = 1'b0;

      // Pipeline-only writes.
      drive_cycle(1, 5'd20, 32'd9898, 0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      check("pipe_write", {26'd0, regWrite, writeAdr, writeData}, {26'd0, 1'b1, 5'd20, 32'd9898});
      drive_cycle(1, 5'd0, 32'd77, 0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      check("pipe_r0", 64'(regWrite), 64'd0);

      // Deferred write appears the cycle after acceptance.
      drive_cycle(0, 5'd0, 32'd0, 1, 5'd21, 32'd6764, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_idle();
      check("deferred", {26'd0, regWrite, writeAdr, writeData}, {26'd0, 1'b1, 5'd21, 32'd6764});
      drive_idle();
      check("deferred_drained", {62'd0, pending, mduReady}, 64'd1);

      // Fill under a held pipeline write, then drain in order.
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1, 5'd5, 32'(i), i < 4, 5'(8 + i), 32'(100 + i), 5'd0, 5'd0, 32'd0, 32'd0);
         if (i == 4) check("full_not_ready", 64'(mduReady), 64'd0);
      end
      for (int i = 0; i < 4; i++) begin
         drive_idle();
         check("drain_order", {26'd0, regWrite, writeAdr, writeData},
               {26'd0, 1'b1, 5'(8 + i), 32'(100 + i)});
      end

      // Kill by a younger pipeline write.
      drive_cycle(1, 5'd5, 32'd1, 1, 5'd30, 32'd111, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_cycle(1, 5'd30, 32'd222, 0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd30, 5'd0, 32'h0000_abcd, 32'd0);
      check("kill_dead_pop", 64'(regWrite), 64'd0);
      check("kill_read_rf", 64'(readData1), 64'h0000_abcd);

      // Bypass picks the youngest live entry.
      drive_cycle(1, 5'd5, 32'd0, 1, 5'd30, 32'd5, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_cycle(1, 5'd5, 32'd0, 1, 5'd30, 32'd7, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_cycle(1, 5'd5, 32'd0, 0, 5'd0, 32'd0, 5'd30, 5'd0, 32'd1111, 32'd2222);
      check("bypass", {readData1, readData2}, {32'd7, 32'd0});
      drive_idle();
      drive_idle();

      // Same-cycle MDU push and pipeline write to one address: MDU entry stays live.
      drive_cycle(1, 5'd12, 32'd1, 1, 5'd12, 32'd2, 5'd0, 5'd0, 32'd0, 32'd0);
      drive_idle();
      check("mdu_younger", {26'd0, regWrite, writeAdr, writeData}, {26'd0, 1'b1, 5'd12, 32'd2});

      // Reset mid-run discards buffered writes.
      for (int i = 0; i < 3; i++)
         drive_cycle(1, 5'd5, 32'd0, 1, 5'(9 + i), 32'(500 + i), 5'd0, 5'd0, 32'd0, 32'd0);
      do_reset();
      repeat (DEPTH + 2) drive_idle();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            drive_cycle($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
         end
      end
      repeat (DEPTH + 2) drive_idle();
      @(negedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, number of deferred-write buffer entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wbValid  input  1  pipeline writeback requests a register write this cycle.
REQ-005 wbAdr  input  5  pipeline destination register.
REQ-006 wbData  input  32  pipeline write data.
REQ-007 mduValid  input  1  multi-cycle unit offers a result.
REQ-008 mduAdr  input  5  multi-cycle unit destination register.
REQ-009 mduData  input  32  multi-cycle unit result.
REQ-010 mduReady  output  1  buffer can accept; transfer occurs when mduValid && mduReady at a rising edge.
REQ-011 regWrite  output  1  write enable to register file write port.
REQ-012 writeAdr  output  5  register file write address.
REQ-013 writeData  output  32  register file write data.
REQ-014 adr1, adr2  input  5 each  register file read addresses (also driven to the register file).
REQ-015 rfData1, rfData2  input  32 each  raw register file read data.
REQ-016 readData1, readData2  output  32 each  read data corrected for buffered writes.
REQ-017 pending  output  1  buffer holds at least one live entry.

Function
REQ-018 Buffer is a DEPTH-entry circular FIFO; each entry holds adr[4:0], data[31:0], live bit; head/tail pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-019 mduReady = (count < DEPTH), from current-cycle count only; a same-cycle pop SHALL NOT make a full buffer ready.
REQ-020 Accepted mdu transfer with mduAdr != 0 is enqueued at tail with live=1; with mduAdr == 0 it is accepted and discarded (no enqueue).
REQ-021 Write port priority per cycle: (1) wbValid && wbAdr != 0 -> regWrite=1, writeAdr=wbAdr, writeData=wbData, no pop; (2) else if count > 0 -> pop head; regWrite=head.live, writeAdr=head.adr, writeData=head.data; (3) else regWrite=0.
REQ-022 wbValid with wbAdr == 0 SHALL NOT write and SHALL NOT block a pop.
REQ-023 Write-port outputs are combinational; pipeline write latency 0 cycles; buffered write earliest in the cycle after acceptance.
REQ-024 When a pipeline write to address A is issued, every buffered entry with adr == A is cleared to live=0 at that edge (pipeline write is younger).
REQ-025 A same-cycle mdu enqueue to A with a pipeline write to A: new entry stays live (mdu result is younger).
REQ-026 Dead entries are still popped in order, one per cycle, with regWrite=0.
REQ-027 Simultaneous push and pop when not full: both occur, count unchanged.
REQ-028 readDataN = 0 if adrN == 0; else data of youngest live entry with adr == adrN; else rfDataN.
REQ-029 Bypass does not include the current-cycle write-port value (register file handles write-then-read).
REQ-030 pending = OR of live bits of occupied entries.
REQ-031 When neither wbValid nor count > 0, writeAdr=0 and writeData=0.

Reset
REQ-032 rst high SHALL immediately empty the buffer (count=0, head=tail=0, all live=0), independent of clk.
REQ-033 While rst is high: regWrite=0, writeAdr=0, writeData=0, mduReady=0, pending=0; readDataN pass rfDataN (0 for address 0).
REQ-034 Reset asserted mid-operation discards all buffered writes; none reach the register file after rst deasserts.

Verification
REQ-035 Pipeline only: wbValid=1, wbAdr=20, wbData=9898 -> same cycle regWrite=1, writeAdr=20, writeData=9898; wbAdr=0 -> regWrite=0.
REQ-036 Deferred write: mdu push (21, 6764) with wbValid=0 -> next cycle regWrite=1, writeAdr=21, writeData=6764, count returns to 0.
REQ-037 Fill/backpressure: wbValid=1 to r5 for 6 cycles, push 4 mdu results to r8..r11 -> mduReady=0 after 4th; release wbValid -> writes r8,r9,r10,r11 on consecutive cycles in order.
REQ-038 Kill: buffer (30, 111), then pipeline write (30, 222) -> entry dead, later pop gives regWrite=0; readData1 at adr1=30 returns rfData1 after the kill edge.
REQ-039 Bypass: buffer (30,5) then (30,7), adr1=30, adr2=0 -> readData1=7, readData2=0 while both pending.
REQ-040 Reset mid-run: 3 entries buffered, pulse rst asynchronously between edges -> count=0, pending=0, regWrite=0 immediately; no buffered write appears afterward.
